// File: rtl/controlador_entrada_rpn_pkg.sv
// Shared types and constants for the RPN calculator input controller.
package rpn_entrada_pkg;

    typedef enum logic [1:0] {
        SOLTO          = 2'd0,
        CONFIRMA_PRESS = 2'd1,
        PRESSIONADO    = 2'd2,
        CONFIRMA_SOLTA = 2'd3
    } estado_debounce_t;

    localparam logic [2:0] OP_SOMA = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    localparam int PROFUNDIDADE_PADRAO = 4;

endpackage

// File: rtl/controlador_entrada_rpn_if.sv
// Button/switch inputs and strobe/data outputs of the RPN input controller.
// master drives the raw board inputs, slave is the controller itself.
interface controlador_entrada_rpn_if;
    logic [1:0] KEY;
    logic [9:0] SW;
    logic       pulso_numero;
    logic       pulso_operacao;
    logic [7:0] valor;
    logic [2:0] codigo_op;
    logic       executar;
    logic [2:0] operandos;
    logic       erro_entrada;

    modport master (
        output KEY, SW,
        input  pulso_numero, pulso_operacao, valor, codigo_op,
               executar, operandos, erro_entrada
    );

    modport slave (
        input  KEY, SW,
        output pulso_numero, pulso_operacao, valor, codigo_op,
               executar, operandos, erro_entrada
    );
endinterface

// File: rtl/controlador_entrada_rpn_debounce.sv
// Debounce FSM for one synchronised button, producing a one-cycle accept.
// Optional macro REPETICAO_AUTO_EN adds auto-repeat while held (REPETE=1).
//
// state          | meaning
// SOLTO          | button released and stable
// CONFIRMA_PRESS | press seen, counting stable pressed cycles
// PRESSIONADO    | press accepted, waiting for release
// CONFIRMA_SOLTA | release seen, counting stable released cycles
module debounce_botao
    import rpn_entrada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS  = 1000000,
    parameter int REPETICAO_CICLOS = 25000000,
    parameter bit REPETE           = 1'b0
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic pressionado,
    output logic aceita
);

    localparam logic [1:0] ST_SOLTO          = SOLTO;
    localparam logic [1:0] ST_CONFIRMA_PRESS = CONFIRMA_PRESS;
    localparam logic [1:0] ST_PRESSIONADO    = PRESSIONADO;
    localparam logic [1:0] ST_CONFIRMA_SOLTA = CONFIRMA_SOLTA;

    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

    if (DEBOUNCE_CICLOS < 1 || REPETICAO_CICLOS < 1 || REPETE > 1'b1) begin : g_param_invalido
        $error("debounce_botao: invalid parameters");
    end

    logic [1:0]    estado;
    logic [1:0]    estado_prox;
    logic [CW-1:0] cnt;
    logic          fim_cnt;
    logic          aceita_deb;

    assign fim_cnt = (cnt == CNT_FIM);

    // Next-state decode; the accept fires on the last stable pressed cycle.
    always_comb begin
        estado_prox = estado;
        aceita_deb  = 1'b0;
        case (estado)
            ST_SOLTO:
                if (pressionado) estado_prox = ST_CONFIRMA_PRESS;
            ST_CONFIRMA_PRESS:
                if (!pressionado) begin
                    estado_prox = ST_SOLTO;
                end else if (fim_cnt) begin
                    estado_prox = ST_PRESSIONADO;
                    aceita_deb  = 1'b1;
                end
            ST_PRESSIONADO:
                if (!pressionado) estado_prox = ST_CONFIRMA_SOLTA;
            ST_CONFIRMA_SOLTA:
                if (pressionado) begin
                    estado_prox = ST_PRESSIONADO;
                end else if (fim_cnt) begin
                    estado_prox = ST_SOLTO;
                end
            default:
                estado_prox = ST_SOLTO;
        endcase
    end

    // State register and stability counter, counter restarts on any state change.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            estado <= ST_SOLTO;
            cnt    <= '0;
        end else begin
            estado <= estado_prox;
            if (estado_prox != estado) begin
                cnt <= '0;
            end else if (!fim_cnt) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef REPETICAO_AUTO_EN
    localparam int RW = (REPETICAO_CICLOS > 1) ? $clog2(REPETICAO_CICLOS) : 1;
    localparam logic [RW-1:0] REP_FIM = RW'(REPETICAO_CICLOS - 1);

    logic [RW-1:0] cnt_rep;
    logic          aceita_rep;

    assign aceita_rep = REPETE && (estado == ST_PRESSIONADO) && pressionado
                        && (cnt_rep == REP_FIM);

    // Repeat period counter, runs only while the accepted press is held.
    always_ff @(posedge CLOCK_50) begin
        if (reset || estado != ST_PRESSIONADO || aceita_rep) begin
            cnt_rep <= '0;
        end else begin
            cnt_rep <= cnt_rep + 1'b1;
        end
    end

    assign aceita = aceita_deb | aceita_rep;
`else
    assign aceita = aceita_deb;
`endif

endmodule

// File: rtl/controlador_entrada_rpn.sv
// RPN calculator input controller: synchronises buttons/switches, debounces
// both keys and turns accepts into push/operation/error strobes while
// tracking stack occupancy. Optional macro REPETICAO_AUTO_EN enables
// auto-repeat of number pushes while KEY[0] is held.
module controlador_entrada_rpn
    import rpn_entrada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS  = 1000000,
    parameter int PROFUNDIDADE     = PROFUNDIDADE_PADRAO,
    parameter int REPETICAO_CICLOS = 25000000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    controlador_entrada_rpn_if.slave bus
);

    localparam logic [2:0] PROF = 3'(PROFUNDIDADE);

    logic [1:0] key_s1, key_s2;
    logic [9:0] sw_s1, sw_s2;
    logic       aceita_num, aceita_op;
    logic       op_pendente;
    logic       op_req;
    logic       unused_sw8;

    logic       pulso_numero_r, pulso_operacao_r, erro_r, executar_r;
    logic [7:0] valor_r;
    logic [2:0] codigo_r, operandos_r;

    assign unused_sw8 = sw_s2[8];

    // Two-flop synchronisers; keys inverted so a press reads as 1.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_s1 <= '0;
            key_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= ~bus.KEY;
            key_s2 <= key_s1;
            sw_s1  <= bus.SW;
            sw_s2  <= sw_s1;
        end
    end

    debounce_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
        .REPETICAO_CICLOS(REPETICAO_CICLOS),
        .REPETE          (1'b1)
    ) u_deb_numero (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .pressionado(key_s2[0]),
        .aceita     (aceita_num)
    );

    debounce_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
        .REPETICAO_CICLOS(REPETICAO_CICLOS),
        .REPETE          (1'b0)
    ) u_deb_operacao (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .pressionado(key_s2[1]),
        .aceita     (aceita_op)
    );

    assign op_req = aceita_op | op_pendente;

    // Request arbitration: numbers win, a colliding operation waits one cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pulso_numero_r   <= 1'b0;
            pulso_operacao_r <= 1'b0;
            erro_r           <= 1'b0;
            executar_r       <= 1'b0;
            valor_r          <= '0;
            codigo_r         <= '0;
            operandos_r      <= '0;
            op_pendente      <= 1'b0;
        end else begin
            pulso_numero_r   <= 1'b0;
            pulso_operacao_r <= 1'b0;
            erro_r           <= 1'b0;
            executar_r       <= sw_s2[9];
            if (aceita_num) begin
                op_pendente <= op_req;
                if (operandos_r < PROF) begin
                    pulso_numero_r <= 1'b1;
                    valor_r        <= sw_s2[7:0];
                    operandos_r    <= operandos_r + 3'd1;
                end else begin
                    erro_r <= 1'b1;
                end
            end else if (op_req) begin
                op_pendente <= 1'b0;
                if (operandos_r >= 3'd2) begin
                    pulso_operacao_r <= 1'b1;
                    codigo_r         <= sw_s2[2:0];
                    operandos_r      <= operandos_r - 3'd1;
                end else begin
                    erro_r <= 1'b1;
                end
            end
        end
    end

    assign bus.pulso_numero   = pulso_numero_r;
    assign bus.pulso_operacao = pulso_operacao_r;
    assign bus.erro_entrada   = erro_r;
    assign bus.executar       = executar_r;
    assign bus.valor          = valor_r;
    assign bus.codigo_op      = codigo_r;
    assign bus.operandos      = operandos_r;

endmodule

// File: tb/tb_controlador_entrada_rpn.sv
// Self-checking bench for controlador_entrada_rpn with short debounce/repeat.
module tb_controlador_entrada_rpn;
    localparam int D = 4;
    localparam int P = 4;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    controlador_entrada_rpn_if bus ();

    controlador_entrada_rpn #(
        .DEBOUNCE_CICLOS (D),
        .PROFUNDIDADE    (P),
        .REPETICAO_CICLOS(R)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tecla;
        logic [9:0] sw;
        logic       pn;
        logic       po;
        logic       err;
        logic [7:0] valor;
        logic [2:0] cod;
        logic [2:0] oper;
    } vetor_t;

    vetor_t tab[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    function automatic logic [2:0] pulsos();
        return {bus.pulso_numero, bus.pulso_operacao, bus.erro_entrada};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int npulsos;
        int nerr;

        tab[0] = '{1, 10'h007, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0};
        tab[1] = '{0, 10'h02A, 1'b1, 1'b0, 1'b0, 8'h2A, 3'd0, 3'd1};
        tab[2] = '{1, 10'h007, 1'b0, 1'b0, 1'b1, 8'h2A, 3'd0, 3'd1};
        tab[3] = '{0, 10'h005, 1'b1, 1'b0, 1'b0, 8'h05, 3'd0, 3'd2};
        tab[4] = '{0, 10'h003, 1'b1, 1'b0, 1'b0, 8'h03, 3'd0, 3'd3};
        tab[5] = '{1, 10'h001, 1'b0, 1'b1, 1'b0, 8'h03, 3'd1, 3'd2};
        tab[6] = '{0, 10'h010, 1'b1, 1'b0, 1'b0, 8'h10, 3'd1, 3'd3};
        tab[7] = '{0, 10'h011, 1'b1, 1'b0, 1'b0, 8'h11, 3'd1, 3'd4};
        tab[8] = '{0, 10'h0FF, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 3'd4};
        tab[9] = '{1, 10'h005, 1'b0, 1'b1, 1'b0, 8'h11, 3'd5, 3'd3};

        bus.KEY = 2'b11;
        bus.SW  = 10'h000;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset pulses", pulsos(), 3'b000);
        chk("reset valor", bus.valor, 8'h00);
        chk("reset codigo_op", bus.codigo_op, 3'd0);
        chk("reset operandos", bus.operandos, 3'd0);
        chk("reset executar", bus.executar, 1'b0);

        // executar follows SW[9] after three edges
        bus.SW = 10'h200;
        repeat (2) tick();
        chk("executar early", bus.executar, 1'b0);
        tick();
        chk("executar set", bus.executar, 1'b1);
        bus.SW = 10'h000;
        repeat (3) tick();
        chk("executar clear", bus.executar, 1'b0);

        // bouncing key never gets accepted
        npulsos = 0;
        for (int k = 0; k < 5; k++) begin
            bus.KEY = 2'b10;
            repeat (2) begin tick(); if (pulsos() != 3'b000) npulsos++; end
            bus.KEY = 2'b11;
            repeat (2) begin tick(); if (pulsos() != 3'b000) npulsos++; end
        end
        repeat (10) begin tick(); if (pulsos() != 3'b000) npulsos++; end
        chk("bounce pulses", npulsos, 0);
        chk("bounce operandos", bus.operandos, 3'd0);

        // table of single presses
        for (int i = 0; i < 10; i++) begin
            bus.SW  = tab[i].sw;
            bus.KEY = (tab[i].tecla == 0) ? 2'b10 : 2'b01;
            repeat (6) tick();
            chk($sformatf("v%0d early pulses", i), pulsos(), 3'b000);
            tick();
            chk($sformatf("v%0d pulso_numero", i), bus.pulso_numero, tab[i].pn);
            chk($sformatf("v%0d pulso_operacao", i), bus.pulso_operacao, tab[i].po);
            chk($sformatf("v%0d erro_entrada", i), bus.erro_entrada, tab[i].err);
            chk($sformatf("v%0d valor", i), bus.valor, tab[i].valor);
            chk($sformatf("v%0d codigo_op", i), bus.codigo_op, tab[i].cod);
            chk($sformatf("v%0d operandos", i), bus.operandos, tab[i].oper);
            tick();
            chk($sformatf("v%0d late pulses", i), pulsos(), 3'b000);
            bus.KEY = 2'b11;
            repeat (10) tick();
        end

        // reset clears stack, then simultaneous accept at operandos=1
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst2 operandos", bus.operandos, 3'd0);
        chk("rst2 valor", bus.valor, 8'h00);
        bus.SW  = 10'h001;
        bus.KEY = 2'b10;
        repeat (7) tick();
        chk("pre push operandos", bus.operandos, 3'd1);
        bus.KEY = 2'b11;
        repeat (10) tick();

        bus.SW  = 10'h009;
        bus.KEY = 2'b00;
        repeat (7) tick();
        chk("both c1 pulses", pulsos(), 3'b100);
        chk("both c1 operandos", bus.operandos, 3'd2);
        chk("both c1 valor", bus.valor, 8'h09);
        tick();
        chk("both c2 pulses", pulsos(), 3'b010);
        chk("both c2 operandos", bus.operandos, 3'd1);
        chk("both c2 codigo_op", bus.codigo_op, 3'd1);
        tick();
        chk("both c3 pulses", pulsos(), 3'b000);
        bus.KEY = 2'b11;
        repeat (10) tick();

        // reset during CONFIRMA_PRESS with key held
        bus.SW  = 10'h044;
        bus.KEY = 2'b10;
        repeat (4) tick();
        rst = 1'b1;
        nerr = 0;
        repeat (3) begin tick(); if (pulsos() != 3'b000) nerr++; end
        chk("pulses during reset", nerr, 0);
        rst = 1'b0;
        chk("mid reset operandos", bus.operandos, 3'd0);
        repeat (6) tick();
        chk("held early pulses", pulsos(), 3'b000);
        tick();
        chk("held pulso_numero", bus.pulso_numero, 1'b1);
        chk("held valor", bus.valor, 8'h44);
        chk("held operandos", bus.operandos, 3'd1);
        npulsos = 0;
        nerr    = 0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (bus.pulso_numero) npulsos++;
            if (bus.erro_entrada || bus.pulso_operacao) nerr++;
`ifdef REPETICAO_AUTO_EN
            if (k == R || k == 2 * R) chk($sformatf("repeat at +%0d", k), bus.pulso_numero, 1'b1);
`endif
        end
`ifdef REPETICAO_AUTO_EN
        chk("repeat count", npulsos, 2);
`else
        chk("no repeat count", npulsos, 0);
`endif
        chk("hold other strobes", nerr, 0);
        bus.KEY = 2'b11;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
